serial_operand_feeder: RTL

Upstream stage for the 4-bit serial adder. It accepts two parallel operands and a carry-in through a valid/ready handshake. It then issues a one-cycle synchronous clear to the adder, streams both operands LSB-first one bit per clock, and holds the carry-in constant for the whole operation. A one-cycle `done` pulse marks the end of each operation.

---
 rtl/serial_operand_feeder_if.sv | 26 ++
 rtl/serial_operand_feeder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/serial_operand_feeder_if.sv
// Operand handshake and serial adder-side signals of the serial_operand_feeder.
interface serial_operand_feeder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             a;
  logic             b;
  logic             carryin;
  logic             adder_rst;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_a, in_b, in_cin,
    input  in_ready, a, b, carryin, adder_rst, busy, done
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    output in_ready, a, b, carryin, adder_rst, busy, done
  );
endinterface

// File: rtl/serial_operand_feeder.sv
// Feeds a serial adder: clear cycle, then WIDTH LSB-first operand bits, then a done pulse.
// Define SERIAL_FEEDER_BACK2BACK_EN to accept the next bundle during the last SHIFT cycle.
module serial_operand_feeder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_operand_feeder_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             carryin_q, carryin_d;
  logic             adder_rst_q, adder_rst_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             ready;
  logic             handshake;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      carryin_q   <= 1'b0;
      adder_rst_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carryin_q   <= carryin_d;
      adder_rst_q <= adder_rst_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    last_bit = (state_q == SHIFT) && (bit_cnt_q == CW'(WIDTH - 1));
`ifdef SERIAL_FEEDER_BACK2BACK_EN
    ready = ((state_q == IDLE) || last_bit) && !rst;
`else
    ready = (state_q == IDLE) && !rst;
`endif
    handshake = bus.in_valid && ready;
  end

  // a/b are registered, so each edge loads the bit that sh_a/sh_b[0] will hold
  // in the following cycle; this keeps a == sh_a[0] throughout SHIFT.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    carryin_d   = carryin_q;
    a_d         = 1'b0;
    b_d         = 1'b0;
    adder_rst_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: ;
      CLEAR: begin
        state_d = SHIFT;
        a_d     = sh_a_q[0];
        b_d     = sh_b_q[0];
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          sh_a_d    = {1'b0, sh_a_q[WIDTH-1:1]};
          sh_b_d    = {1'b0, sh_b_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + CW'(1);
          a_d       = sh_a_q[1];
          b_d       = sh_b_q[1];
        end
      end
      default: state_d = IDLE;
    endcase

    if (handshake) begin
      state_d     = CLEAR;
      sh_a_d      = bus.in_a;
      sh_b_d      = bus.in_b;
      carryin_d   = bus.in_cin;
      bit_cnt_d   = '0;
      adder_rst_d = 1'b1;
      a_d         = 1'b0;
      b_d         = 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.carryin   = carryin_q;
  assign bus.adder_rst = adder_rst_q;
  assign bus.done      = done_q;

endmodule
